// File: rtl/fas_pkg.sv
// rtl/fas_pkg.sv - FAS front-end FIR defaults, Q4.16 default coefficient table and round/saturate helper
package fas_pkg;

  localparam int FIR_TAPS   = 32;
  localparam int FIR_DATA_W = 16;
  localparam int FIR_COEF_W = 20;
  localparam int FIR_FRAC   = 16;
  localparam int FIR_OUT_W  = 16;

  typedef logic signed [19:0] fir_coef_t;

  // Symmetric low-pass prototype, Q4.16
  localparam fir_coef_t FIR_COEF_DEFAULT [32] = '{
    -20'sd96,   -20'sd120,  -20'sd84,   20'sd0,
    20'sd112,   20'sd208,   20'sd220,   20'sd96,
    -20'sd160,  -20'sd456,  -20'sd640,  -20'sd520,
    20'sd72,    20'sd3200,  20'sd8200,  20'sd15016,
    20'sd15016, 20'sd8200,  20'sd3200,  20'sd72,
    -20'sd520,  -20'sd640,  -20'sd456,  -20'sd160,
    20'sd96,    20'sd220,   20'sd208,   20'sd112,
    20'sd0,     -20'sd84,   -20'sd120,  -20'sd96
  };

  typedef struct packed {
    logic               sat;
    logic signed [63:0] y;
  } sat_res_t;

  // Round half toward +inf, drop frac bits, clip to a signed out_w-bit range
  function automatic sat_res_t sat_round(input logic signed [63:0] acc, input int frac, input int out_w);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_res_t res;
    r  = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    res.sat = (r > hi) || (r < lo);
    res.y   = (r > hi) ? hi : ((r < lo) ? lo : r);
    return res;
  endfunction

endpackage

// File: rtl/fir_adder_tree.sv
// rtl/fir_adder_tree.sv - registered binary adder tree, zero padded to a power of two, valid passthrough
module fir_adder_tree #(
  parameter int N    = 32,
  parameter int IN_W = 36
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             in_valid,
  input  logic signed [IN_W-1:0]           in_data [N],
  output logic                             out_valid,
  output logic signed [IN_W+$clog2(N)-1:0] out_data
);
  localparam int L  = $clog2(N);
  localparam int NP = 1 << L;

  // Level g holds NP>>g partial sums, each one bit wider than the level below
  for (genvar g = 0; g <= L; g++) begin : lvl
    logic signed [IN_W+g-1:0] s [NP >> g];
    logic                     v;

    if (g == 0) begin : g_in
      always_comb begin
        for (int i = 0; i < N; i++) s[i] = in_data[i];
        for (int i = N; i < NP; i++) s[i] = '0;
      end
      assign v = in_valid;
    end else begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v <= 1'b0;
          for (int i = 0; i < (NP >> g); i++) s[i] <= '0;
        end else begin
          v <= flush ? 1'b0 : lvl[g-1].v;
          for (int i = 0; i < (NP >> g); i++)
            s[i] <= (IN_W+g)'(lvl[g-1].s[2*i]) + (IN_W+g)'(lvl[g-1].s[2*i+1]);
        end
      end
    end
  end

  assign out_data  = lvl[L].s[0];
  assign out_valid = lvl[L].v;

endmodule

// File: rtl/fir_filter_pipe.sv
// rtl/fir_filter_pipe.sv - pipelined direct-form FIR: loadable coefs, warm-up gating, round-half-up, saturation
module fir_filter_pipe
  import fas_pkg::*;
#(
  parameter int TAPS   = FIR_TAPS,
  parameter int DATA_W = FIR_DATA_W,
  parameter int COEF_W = FIR_COEF_W,
  parameter int FRAC   = FIR_FRAC,
  parameter int OUT_W  = FIR_OUT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      in_valid,
  input  logic signed [DATA_W-1:0]  in_data,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]  coef_wdata,
  output logic                      out_valid,
  output logic signed [OUT_W-1:0]   out_data,
  output logic                      out_sat,
  output logic                      win_full
);
  localparam int L      = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + L;
  localparam int CNT_W  = $clog2(TAPS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TAPS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TAPS - 1);

  logic signed [DATA_W-1:0] dl   [TAPS];
  logic signed [COEF_W-1:0] coef [TAPS];
  logic signed [PROD_W-1:0] prod [TAPS];
  logic [CNT_W-1:0]         cnt;
  logic                     dl_valid;
  logic                     prod_valid;
  logic                     sum_valid;
  logic signed [ACC_W-1:0]  sum;
  sat_res_t                 res;

  function automatic logic signed [COEF_W-1:0] coef_init(input int k);
    if (TAPS == 32) return COEF_W'(FIR_COEF_DEFAULT[k[4:0]]);
    return '0;
  endfunction

  // The valid tag is decided on the pre-increment count: the TAPS-th sample is the first tagged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      win_full <= 1'b0;
      dl_valid <= 1'b0;
      for (int k = 0; k < TAPS; k++) dl[k] <= '0;
    end else if (clear) begin
      cnt      <= '0;
      win_full <= 1'b0;
      dl_valid <= 1'b0;
      for (int k = 0; k < TAPS; k++) dl[k] <= '0;
    end else begin
      dl_valid <= in_valid && (cnt >= CNT_LAST);
      if (in_valid) begin
        dl[0] <= in_data;
        for (int k = 1; k < TAPS; k++) dl[k] <= dl[k-1];
        if (cnt != CNT_FULL) cnt <= cnt + CNT_W'(1);
        if (cnt >= CNT_LAST) win_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) coef[k] <= coef_init(k);
    end else if (coef_we) begin
      coef[coef_addr] <= coef_wdata;
    end
  end

  // Products read coef one cycle after the sample, so a same-cycle write already applies
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_valid <= 1'b0;
      for (int k = 0; k < TAPS; k++) prod[k] <= '0;
    end else begin
      prod_valid <= dl_valid && !clear;
      for (int k = 0; k < TAPS; k++) prod[k] <= PROD_W'(dl[k]) * PROD_W'(coef[k]);
    end
  end

  fir_adder_tree #(
    .N    (TAPS),
    .IN_W (PROD_W)
  ) u_tree (
    .clk       (clk),
    .rst       (rst),
    .flush     (clear),
    .in_valid  (prod_valid),
    .in_data   (prod),
    .out_valid (sum_valid),
    .out_data  (sum)
  );

  assign res = sat_round(64'(sum), FRAC, OUT_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      out_valid <= sum_valid && !clear;
      if (sum_valid && !clear) begin
        out_data <= OUT_W'(res.y);
        out_sat  <= res.sat;
      end
    end
  end

endmodule

// File: tb/tb_fir_filter_pipe.sv
// tb/tb_fir_filter_pipe.sv - directed bench for fir_filter_pipe against an arithmetic reference model
module tb_fir_filter_pipe;
  localparam int TAPS = 32;
  localparam int LAT  = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               clear = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [15:0] in_data = '0;
  logic               coef_we = 1'b0;
  logic [4:0]         coef_addr = '0;
  logic signed [19:0] coef_wdata = '0;
  logic               out_valid;
  logic signed [15:0] out_data;
  logic               out_sat;
  logic               win_full;

  always #5 clk = ~clk;

  fir_filter_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_sat    (out_sat),
    .win_full   (win_full)
  );

  localparam longint COEF_DEF [32] = '{
    -96, -120, -84, 0, 112, 208, 220, 96, -160, -456, -640, -520, 72, 3200, 8200, 15016,
    15016, 8200, 3200, 72, -520, -640, -456, -160, 96, 220, 208, 112, 0, -84, -120, -96
  };

  typedef struct { longint data; bit sat; int due; } exp_t;
  typedef struct { longint data; bit sat; int cyc; } obs_t;

  int       total = 0;
  int       bad = 0;
  int       cyc = 0;
  int       last_in = 0;
  int       cnt_m = 0;
  exp_t     expq[$];
  obs_t     obs[$];
  longint   hist[$];
  longint   coef_m [TAPS];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic obs_chk(input string name, input int idx, input longint exp);
    if (idx < obs.size()) chk(name, obs[idx].data, exp);
    else begin
      total++;
      bad++;
      $display("FAIL %s: got no output #%0d want %0d", name, idx, exp);
    end
  endtask

  task automatic last_chk(input string name, input longint exp, input bit exp_sat);
    if (obs.size() > 0) begin
      chk({name, "_data"}, obs[obs.size()-1].data, exp);
      chk({name, "_sat"}, obs[obs.size()-1].sat, exp_sat);
    end else begin
      total++;
      bad++;
      $display("FAIL %s: got no output want %0d", name, exp);
    end
  endtask

  task automatic model_reset();
    expq.delete();
    hist.delete();
    cnt_m = 0;
    for (int k = 0; k < TAPS; k++) coef_m[k] = COEF_DEF[k];
  endtask

  // y[n] = sum_k c[k]*x[n-k], rounded half up, clipped; due LAT cycles after the sample's cycle
  task automatic model_edge();
    longint acc;
    longint y;
    bit     s;
    if (rst) return;
    if (coef_we) coef_m[coef_addr] = coef_wdata;
    if (clear) begin
      hist.delete();
      cnt_m = 0;
      expq.delete();
      return;
    end
    if (!in_valid) return;
    hist.push_front(in_data);
    if (hist.size() > TAPS) void'(hist.pop_back());
    if (cnt_m < TAPS) cnt_m++;
    if (cnt_m < TAPS) return;
    acc = 0;
    for (int k = 0; k < TAPS; k++) acc += coef_m[k] * hist[k];
    y = (acc + 32768) >>> 16;
    s = 1'b0;
    if (y > 32767) begin y = 32767; s = 1'b1; end
    else if (y < -32768) begin y = -32768; s = 1'b1; end
    expq.push_back('{data: y, sat: s, due: cyc + LAT - 1});
  endtask

  task automatic step(input bit v = 1'b0, input longint d = 0, input bit clr = 1'b0);
    in_valid = v;
    in_data  = 16'(d);
    clear    = clr;
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    coef_we = 1'b0;
  endtask

  task automatic wr_step(input int a, input longint w, input bit v = 1'b0, input longint d = 0, input bit clr = 1'b0);
    coef_we    = 1'b1;
    coef_addr  = 5'(a);
    coef_wdata = 20'(w);
    step(v, d, clr);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (expq.size() > 0 && expq[0].due == cyc) begin
        chk("out_valid", out_valid, 1);
        chk("out_data", out_data, expq[0].data);
        chk("out_sat", out_sat, expq[0].sat);
        void'(expq.pop_front());
      end else begin
        chk("out_valid_idle", out_valid, 0);
      end
      chk("win_full", win_full, cnt_m == TAPS);
      if (out_valid) obs.push_back('{data: out_data, sat: out_sat, cyc: cyc});
    end
  end

  initial begin
    model_reset();
    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_win_full", win_full, 0);
    step();
    step();
    rst = 1'b0;

    // Impulse through the default coefficients
    obs.delete();
    for (int i = 0; i < 32; i++) step(1'b1, 0);
    last_in = cyc;
    step(1'b1, 16384);
    for (int i = 0; i < 40; i++) step(1'b1, 0);
    repeat (LAT + 2) step();
    chk("t1_count", obs.size(), 42);
    obs_chk("t1_first", 0, 0);
    obs_chk("t1_c0", 1, -24);
    obs_chk("t1_c1", 2, -30);
    obs_chk("t1_c2", 3, -21);
    obs_chk("t1_c15", 16, 3754);
    // Sample taken at edge P lands in cycle t+LAT, which begins at edge P+LAT-1
    if (obs.size() > 0) chk("t1_latency", obs[0].cyc - last_in, LAT - 1);
    else chk("t1_latency", -1, LAT - 1);

    // Saturation with unity taps
    step(1'b0, 0, 1'b1);
    for (int k = 0; k < 32; k++) wr_step(k, 65536);
    obs.delete();
    for (int i = 0; i < 40; i++) step(1'b1, 32767);
    repeat (LAT + 2) step();
    last_chk("t2_pos", 32767, 1'b1);
    obs.delete();
    for (int i = 0; i < 40; i++) step(1'b1, -32768);
    repeat (LAT + 2) step();
    last_chk("t2_neg", -32768, 1'b1);

    // Gapped input, 1-0-0-1 pattern
    step(1'b0, 0, 1'b1);
    obs.delete();
    for (int i = 0; i < 128; i++) begin
      longint d;
      d = (i < 64) ? 100 : ((i * 37) % 200) - 100;
      step(((i % 4) == 0) || ((i % 4) == 3), d);
    end
    repeat (LAT + 2) step();
    chk("t3_count", obs.size(), 33);
    obs_chk("t3_first", 0, 3200);
    obs_chk("t3_second", 1, 3168);
    if (obs.size() > 2) begin
      chk("t3_gap_a", obs[1].cyc - obs[0].cyc, 1);
      chk("t3_gap_b", obs[2].cyc - obs[1].cyc, 3);
    end else chk("t3_gap", obs.size(), 3);

    // Coefficient write alongside a sample, plus rounding boundaries
    step(1'b0, 0, 1'b1);
    for (int k = 0; k < 32; k++) wr_step(k, 0);
    wr_step(0, 65536);
    obs.delete();
    for (int i = 0; i < 31; i++) step(1'b1, 10);
    step(1'b1, 100);
    wr_step(0, 131072, 1'b1, 200);
    step(1'b1, 300);
    wr_step(0, 32768);
    step(1'b1, 3);
    step(1'b1, -3);
    step(1'b1, 5);
    repeat (LAT + 2) step();
    obs_chk("t4_old_coef", 0, 100);
    obs_chk("t4_same_cycle", 1, 400);
    obs_chk("t4_after", 2, 600);
    obs_chk("t4_round_pos", 3, 2);
    obs_chk("t4_round_neg", 4, -1);
    obs_chk("t4_round_2p5", 5, 3);

    // Clear mid-stream, with a sample and a coefficient write in the same cycle
    for (int i = 0; i < 40; i++) step(1'b1, 7);
    wr_step(0, 196608, 1'b1, 7, 1'b1);
    #2;
    chk("t5_valid_after_clear", out_valid, 0);
    chk("t5_win_after_clear", win_full, 0);
    obs.delete();
    for (int i = 0; i < 31; i++) step(1'b1, 7);
    repeat (LAT + 2) step();
    chk("t5_no_out", obs.size(), 0);
    step(1'b1, 7);
    repeat (LAT + 2) step();
    chk("t5_one_out", obs.size(), 1);
    obs_chk("t5_new_coef", 0, 21);

    // Asynchronous reset between edges
    for (int i = 0; i < 20; i++) step(1'b1, 7);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_out_data", out_data, 0);
    chk("t6_out_sat", out_sat, 0);
    chk("t6_win_full", win_full, 0);
    step();
    rst = 1'b0;
    obs.delete();
    for (int i = 0; i < 31; i++) step(1'b1, 0);
    repeat (LAT + 2) step();
    chk("t6_warmup", obs.size(), 0);
    step(1'b1, 16384);
    repeat (LAT + 2) step();
    obs_chk("t6_default_c0", 0, -24);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
